store_result_monitor: RTL
=========================

Name: store_result_monitor

Overview:
- Synthesizable, parametrised self-check monitor on the single-cycle core's data-memory write bus (memWrite, dataAddress, storeData).
- Decides PASS when the program stores the expected result word to the expected address, and FAIL on any write outside the permitted scratch window.
- Adds a cycle watchdog, a minimum scratch-write requirement, store counters and capture of the offending store.
- Sits beside the data memory in the top level; its outputs drive FPGA LEDs or are read by the bench.

Parameters:
- DATA_W, 32, width of dataAddress/storeData.
- PASS_ADDR, 100, address of the terminating result store.
- PASS_DATA, 25, required value of the result store.
- SCRATCH_BASE, 96, first byte address of the permitted scratch window.
- SCRATCH_BYTES, 4, size of the scratch window in bytes; 0 = no scratch window.
- MIN_SCRATCH, 0, scratch writes required before a result store counts as PASS.
- TIMEOUT_CYCLES, 1000, enabled cycles before TIMEOUT; 0 disables the watchdog.
- CNT_W, 16, width of all counters.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  monitoring/counting enable; low freezes all state.
- memWrite  input  1  data-memory write strobe.
- dataAddress  input  DATA_W  write byte address.
- storeData  input  DATA_W  write data.
- done  output  1  high in any terminal state.
- pass  output  1  PASS reached.
- fail  output  1  FAIL reached.
- timeout  output  1  TIMEOUT reached.
- storeCount  output  CNT_W  total accepted writes seen while in RUN.
- scratchCount  output  CNT_W  scratch-window writes seen.
- cycleCount  output  CNT_W  enabled cycles spent in RUN.
- failAddress  output  DATA_W  dataAddress of the failing store.
- failData  output  DATA_W  storeData of the failing store.

Behaviour:
- One clock, clk. Reset is synchronous and active-high, on port reset. All inputs are sampled on the rising edge of clk. All outputs are registered.
- Reset forces: state RUN, done/pass/fail/timeout 0, all counters 0, failAddress/failData 0. Reset overrides every other event, including mid-run and in a terminal state.
- States: RUN, PASS, FAIL, TIMEOUT. The three terminal states are sticky until reset.
- In RUN with enable=1, each cycle:
  - cycleCount increments, saturating at all-ones.
  - If memWrite=1, storeCount increments (saturating), then classify the store in strict priority order:
    1. dataAddress==PASS_ADDR and storeData==PASS_DATA: go to PASS if scratchCount (value before this cycle) >= MIN_SCRATCH, otherwise go to FAIL and capture the store.
    2. SCRATCH_BASE <= dataAddress < SCRATCH_BASE+SCRATCH_BYTES, compared as unsigned at DATA_W+1 bits so there is no wrap: scratchCount increments (saturating); stay in RUN.
    3. Anything else, including PASS_ADDR with wrong data: go to FAIL; failAddress<=dataAddress, failData<=storeData.
  - Watchdog: if TIMEOUT_CYCLES!=0, cycleCount (value before increment)==TIMEOUT_CYCLES-1, and no store caused a transition this cycle, go to TIMEOUT. A terminating store in the same cycle takes precedence over TIMEOUT.
- In RUN with enable=0: no state change, no counter change, memWrite ignored.
- In terminal states: counters and captures frozen; inputs ignored.
- Flag decode: pass=(state==PASS), fail=(state==FAIL), timeout=(state==TIMEOUT), done=pass|fail|timeout. Exactly one flag is high when done=1.
- Latency: the flag asserts in the cycle after the deciding edge, i.e. visible the same clk period the core's next instruction executes.
- failAddress/failData are written only on entry to FAIL. On MIN_SCRATCH-underflow FAIL they hold the result store.

Test Plan:
- Reset, enable=1; writes (96,7), (96,11), then (100,25) -> pass=1 on the cycle after the third write; scratchCount=2, storeCount=3, fail=0; further writes (200,1) leave outputs unchanged.
- Write (100,24) -> fail=1, failAddress=100, failData=24, scratchCount=0; a later (100,25) does not set pass.
- Write (104,25) with SCRATCH_BYTES=4 -> fail=1, failAddress=104; write (99,x) stays in RUN, scratchCount=1.
- MIN_SCRATCH=2: writes (96,1), (100,25) -> fail=1, failAddress=100, failData=25.
- TIMEOUT_CYCLES=10, no writes -> timeout=1 after exactly 10 enabled cycles, cycleCount=10. Repeat with (100,25) on the 10th cycle -> pass=1, timeout=0. Toggling enable low for 5 cycles delays timeout by 5.
- Assert reset for one cycle while in PASS -> all outputs 0, state RUN; a subsequent pass sequence passes again.

Source files
------------

// File: rtl/store_result_monitor.sv
// Self-check monitor on the core's data-memory write bus: declares PASS on the expected
// result store, FAIL on any write outside the scratch window, TIMEOUT from a cycle watchdog.
module store_result_monitor #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned PASS_ADDR      = 100,
   parameter int unsigned PASS_DATA      = 25,
   parameter int unsigned SCRATCH_BASE   = 96,
   parameter int unsigned SCRATCH_BYTES  = 4,
   parameter int unsigned MIN_SCRATCH    = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              memWrite,
   input  logic [DATA_W-1:0] dataAddress,
   input  logic [DATA_W-1:0] storeData,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CNT_W-1:0]  storeCount,
   output logic [CNT_W-1:0]  scratchCount,
   output logic [CNT_W-1:0]  cycleCount,
   output logic [DATA_W-1:0] failAddress,
   output logic [DATA_W-1:0] failData
);

   typedef enum logic [1:0] {RUN, PASS, FAIL, TIMEOUT} state_e;

   localparam int unsigned DW1 = DATA_W + 1;
   // Window bounds carry one extra bit so a window ending at the top of the address space cannot wrap.
   localparam logic [DATA_W:0] SCRATCH_LO = DW1'(SCRATCH_BASE);
   localparam logic [DATA_W:0] SCRATCH_HI = DW1'(SCRATCH_BASE) + DW1'(SCRATCH_BYTES);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIN_SCR      = CNT_W'(MIN_SCRATCH);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  storeCount_q, storeCount_d;
   logic [CNT_W-1:0]  scratchCount_q, scratchCount_d;
   logic [CNT_W-1:0]  cycleCount_q, cycleCount_d;
   logic [DATA_W-1:0] failAddress_q, failAddress_d;
   logic [DATA_W-1:0] failData_q, failData_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              timeout_q, timeout_d;

   logic isResult;
   logic inScratch;
   logic watchdogHit;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign isResult    = (dataAddress == DATA_W'(PASS_ADDR)) && (storeData == DATA_W'(PASS_DATA));
   assign inScratch   = ({1'b0, dataAddress} >= SCRATCH_LO) && ({1'b0, dataAddress} < SCRATCH_HI);
   assign watchdogHit = (TIMEOUT_CYCLES != 0) && (cycleCount_q == TIMEOUT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         storeCount_q   <= '0;
         scratchCount_q <= '0;
         cycleCount_q   <= '0;
         failAddress_q  <= '0;
         failData_q     <= '0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         fail_q         <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         storeCount_q   <= storeCount_d;
         scratchCount_q <= scratchCount_d;
         cycleCount_q   <= cycleCount_d;
         failAddress_q  <= failAddress_d;
         failData_q     <= failData_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         fail_q         <= fail_d;
         timeout_q      <= timeout_d;
      end
   end

   // A terminating store outranks the watchdog when both land on the same cycle.
   always_comb begin
      state_d        = state_q;
      storeCount_d   = storeCount_q;
      scratchCount_d = scratchCount_q;
      cycleCount_d   = cycleCount_q;
      failAddress_d  = failAddress_q;
      failData_d     = failData_q;
      if (state_q == RUN && enable) begin
         cycleCount_d = satInc(cycleCount_q);
         if (memWrite) begin
            storeCount_d = satInc(storeCount_q);
            if (isResult) begin
               if (scratchCount_q >= MIN_SCR) begin
                  state_d = PASS;
               end else begin
                  state_d       = FAIL;
                  failAddress_d = dataAddress;
                  failData_d    = storeData;
               end
            end else if (inScratch) begin
               scratchCount_d = satInc(scratchCount_q);
            end else begin
               state_d       = FAIL;
               failAddress_d = dataAddress;
               failData_d    = storeData;
            end
         end
         if (state_d == RUN && watchdogHit) begin
            state_d = TIMEOUT;
         end
      end
   end

   always_comb begin
      pass_d    = (state_d == PASS);
      fail_d    = (state_d == FAIL);
      timeout_d = (state_d == TIMEOUT);
      done_d    = (state_d != RUN);
   end

   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign storeCount   = storeCount_q;
   assign scratchCount = scratchCount_q;
   assign cycleCount   = cycleCount_q;
   assign failAddress  = failAddress_q;
   assign failData     = failData_q;

endmodule
